// File: rtl/dtree_top_if.sv
// Sample/result bundle for the depth-2 decision-tree classifier:
// one feature sample in and one registered class label out.
interface dtree_top_if;
    logic       in_valid;
    logic [7:0] X5;
    logic       out_valid;
    logic       out;

    modport master (
        output in_valid,
        output X5,
        input  out_valid,
        input  out
    );

    modport slave (
        input  in_valid,
        input  X5,
        output out_valid,
        output out
    );
endinterface

// File: rtl/dtree_top.sv
// Single-feature depth-2 threshold tree on X5; the class label is registered
// one cycle after a valid sample, and outputs come straight from flops.
module dtree_top #(
    parameter logic [7:0] T_ROOT  = 8'd127,
    parameter logic [7:0] T_LEFT  = 8'd63,
    parameter logic [7:0] T_RIGHT = 8'd191,
    parameter logic       LEAF_LL = 1'b0,
    parameter logic       LEAF_LR = 1'b1,
    parameter logic       LEAF_RL = 1'b0,
    parameter logic       LEAF_RR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    dtree_top_if.slave  bus
);

    logic class_next;
    logic out_q;
    logic out_valid_q;

    // Tree is evaluated literally; "<=" always takes the left branch.
    always_comb begin
        // NOTE: default first so every path assigns class_next and no latch is inferred.
        class_next = LEAF_LL;
        if (bus.X5 <= T_ROOT) begin
            class_next = (bus.X5 <= T_LEFT) ? LEAF_LL : LEAF_LR;
        end else begin
            class_next = (bus.X5 <= T_RIGHT) ? LEAF_RL : LEAF_RR;
        end
    end

    // Reset wins over in_valid, so a sample arriving with rst is dropped.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep flop updates order-independent.
        if (rst) begin
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                out_q <= class_next;
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_dtree_top.sv
// Directed self-checking bench for dtree_top with default tree parameters.
module tb_dtree_top;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    dtree_top_if bus ();

    dtree_top dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference written as value ranges of the default tree.
    function automatic logic ref_class(input logic [7:0] x);
        if (x < 8'd64)       return 1'b0;
        else if (x < 8'd128) return 1'b1;
        else if (x < 8'd192) return 1'b0;
        else                 return 1'b1;
    endfunction

    // Advance one rising edge and settle before sampling outputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.X5 = 8'd200;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if (bus.out !== 1'b0) begin
                fails++;
                $display("FAIL reset_out cyc%0d got=%b exp=0", i, bus.out);
            end
            tests++;
            if (bus.out_valid !== 1'b0) begin
                fails++;
                $display("FAIL reset_valid cyc%0d got=%b exp=0", i, bus.out_valid);
            end
        end
        rst = 1'b0;
        tick();
        tests++;
        if (bus.out !== 1'b1 || bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL post_reset got out=%b valid=%b exp out=1 valid=1",
                     bus.out, bus.out_valid);
        end
    endtask

    task automatic test_vectors(input string name, input logic [7:0] xs[],
                                input logic exps[]);
        for (int i = 0; i < xs.size(); i++) begin
            bus.in_valid = 1'b1;
            bus.X5 = xs[i];
            tick();
            tests++;
            if (bus.out !== exps[i] || bus.out_valid !== 1'b1) begin
                fails++;
                $display("FAIL %s X5=%0d got out=%b valid=%b exp out=%b valid=1",
                         name, xs[i], bus.out, bus.out_valid, exps[i]);
            end
        end
    endtask

    task automatic test_leaves();
        logic [7:0] xs[]   = '{8'd10, 8'd100, 8'd150, 8'd250};
        logic       exps[] = '{1'b0, 1'b1, 1'b0, 1'b1};
        test_vectors("leaf", xs, exps);
    endtask

    task automatic test_boundaries();
        logic [7:0] xs[]   = '{8'd63, 8'd64, 8'd127, 8'd128, 8'd191, 8'd192, 8'd0, 8'd255};
        logic       exps[] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        test_vectors("boundary", xs, exps);
    endtask

    task automatic test_hold();
        bus.in_valid = 1'b1;
        bus.X5 = 8'd100;
        tick();
        tests++;
        if (bus.out !== 1'b1 || bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL hold_load got out=%b valid=%b exp out=1 valid=1",
                     bus.out, bus.out_valid);
        end
        bus.in_valid = 1'b0;
        bus.X5 = 8'd250;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (bus.out !== 1'b1 || bus.out_valid !== 1'b0) begin
                fails++;
                $display("FAIL hold cyc%0d got out=%b valid=%b exp out=1 valid=0",
                         i, bus.out, bus.out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] x;
        for (int i = 0; i < 256; i++) begin
            x = 8'(i);
            bus.in_valid = 1'b1;
            bus.X5 = x;
            tick();
            tests++;
            if (bus.out !== ref_class(x) || bus.out_valid !== 1'b1) begin
                fails++;
                $display("FAIL stream X5=%0d got out=%b valid=%b exp out=%b valid=1",
                         i, bus.out, bus.out_valid, ref_class(x));
            end
        end
    endtask

    task automatic test_mid_reset();
        bus.in_valid = 1'b1;
        bus.X5 = 8'd100;
        tick();
        rst = 1'b1;
        bus.X5 = 8'd250;
        tick();
        tests++;
        if (bus.out !== 1'b0 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset got out=%b valid=%b exp out=0 valid=0",
                     bus.out, bus.out_valid);
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        tests++;
        if (bus.out !== 1'b0 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_drop got out=%b valid=%b exp out=0 valid=0",
                     bus.out, bus.out_valid);
        end
        bus.in_valid = 1'b1;
        bus.X5 = 8'd100;
        tick();
        tests++;
        if (bus.out !== 1'b1 || bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset_resume got out=%b valid=%b exp out=1 valid=1",
                     bus.out, bus.out_valid);
        end
        bus.X5 = 8'd150;
        tick();
        tests++;
        if (bus.out !== 1'b0 || bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset_resume2 got out=%b valid=%b exp out=0 valid=1",
                     bus.out, bus.out_valid);
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.X5 = 8'd0;
        test_reset();
        test_leaves();
        test_boundaries();
        test_hold();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dtree_top.md
# dtree_top

Single-feature binary decision-tree classifier for the mammographic-mass model. It samples the 8-bit feature X5, walks a depth-2 threshold tree and produces a 1-bit class label one clock later. It is the top-level inference block of the printed-tree flow; the surrounding harness drives one feature sample per cycle and records `out`.

## Interface
Parameters:
- `T_ROOT`, default 8'd127: root threshold.
- `T_LEFT`, default 8'd63: threshold of the left child.
- `T_RIGHT`, default 8'd191: threshold of the right child.
- `LEAF_LL`, default 1'b0: class when X5 <= T_LEFT.
- `LEAF_LR`, default 1'b1: class when T_LEFT < X5 <= T_ROOT.
- `LEAF_RL`, default 1'b0: class when T_ROOT < X5 <= T_RIGHT.
- `LEAF_RR`, default 1'b1: class when X5 > T_RIGHT.

Ports:
- `clk` input, 1 bit: the single clock. All state updates on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in_valid` input, 1 bit: X5 holds a sample to classify this cycle.
- `X5` input, 8 bits: unsigned feature value.
- `out_valid` output, 1 bit: `out` carries a fresh classification.
- `out` output, 1 bit: predicted class (0 = benign, 1 = malignant).

## Operation
- All comparisons are unsigned 8-bit; "<=" selects the left branch at every node.
- Root node:
  - X5 <= T_ROOT goes to the left child.
  - Otherwise it goes to the right child.
- Left child: X5 <= T_LEFT gives LEAF_LL, else LEAF_LR.
- Right child: X5 <= T_RIGHT gives LEAF_RL, else LEAF_RR.
- Threshold ordering T_LEFT <= T_ROOT <= T_RIGHT is expected but not checked. Any values are legal; the tree is evaluated literally.
- The next-state class is computed combinationally from X5 and is registered only when in_valid = 1.
- When in_valid = 0:
  - `out` holds its previous value.
  - `out_valid` is 0.
- There is no backpressure. Every valid input produces exactly one valid output.

## Timing
- Latency is 1 cycle. A sample presented with in_valid = 1 before rising edge N appears on `out` with out_valid = 1 after edge N.
- Throughput is one sample per cycle. Back-to-back valid inputs produce back-to-back valid outputs.
- Outputs are driven directly from flops. There is no combinational path from inputs to outputs.
- Reset:
  - With rst = 1 at a rising edge, `out` = 0 and `out_valid` = 0 after that edge.
  - Reset has priority over in_valid.
  - A sample accepted in the same cycle as rst is discarded.
- Reset mid-stream: outputs clear at the reset edge, and the first valid output appears 1 cycle after the first post-reset valid input.
- X5 and in_valid may change arbitrarily while in_valid = 0 without effect.

## Test plan
- Reset:
  - Assert rst for 2 cycles with in_valid = 1 and X5 = 200 → out = 0 and out_valid = 0 throughout.
  - Deassert rst → the next edge gives out = 1, out_valid = 1.
- Leaf coverage, one cycle each with default parameters:
  - X5 = 10 → out = 0 (LL).
  - X5 = 100 → out = 1 (LR).
  - X5 = 150 → out = 0 (RL).
  - X5 = 250 → out = 1 (RR).
  - Each result appears exactly 1 cycle later with out_valid = 1.
- Boundaries with default parameters:
  - X5 = 63 → 0, and X5 = 64 → 1.
  - X5 = 127 → 1, and X5 = 128 → 0.
  - X5 = 191 → 0, and X5 = 192 → 1.
  - X5 = 0 → 0, and X5 = 255 → 1.
- Hold behaviour:
  - Send X5 = 100 valid, then 3 cycles with in_valid = 0 and X5 = 250 → out stays 1 and out_valid is 0 for those 3 cycles.
- Streaming:
  - Drive all 256 X5 values back-to-back from a file, one per cycle.
  - The output stream matches a reference model shifted by 1 cycle, with out_valid continuously 1.
- Mid-stream reset:
  - Assert rst for 1 cycle during streaming → out = 0 and out_valid = 0 the next cycle.
  - The classification in flight during the reset cycle is dropped.
  - Streaming resumes with 1-cycle latency.
